buffer_write_arbiter: RTL and testbench



---
 rtl/router_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/buffer_write_arbiter.sv | 126 ++++++++++++
 tb/tb_buffer_write_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types: flit width, arbiter FSM states and the port-index type.
package router_pkg;

    localparam int FLIT_WIDTH    = 64;
    localparam int NUM_PORTS_DEF = 4;
    localparam int PORT_IDX_W    = $clog2(NUM_PORTS_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: the first requester at or after
// ptr (wrapping) wins. Shared with the output scheduler.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [PW:0] k;

    // Scan upward from ptr; the extra bit of k absorbs the wrap before the modulo.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = {1'b0, ptr} + (PW+1)'(i);
            if (k >= (PW+1)'(N))
                k = k - (PW+1)'(N);
            if (!valid && req[k[PW-1:0]]) begin
                gnt[k[PW-1:0]] = 1'b1;
                valid          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffer_write_arbiter.sv
// Packet-granular round-robin write arbiter in front of the shared FIFO.
// A grant is held for a whole packet; a packet only starts when the FIFO
// has room for a maximum-length packet.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; pick next requester once a full packet fits
// LOCK  | grant held; flits of the granted port stream into the FIFO
module buffer_write_arbiter #(
    parameter int NUM_PORTS     = router_pkg::NUM_PORTS_DEF,
    parameter int FLIT_WIDTH    = router_pkg::FLIT_WIDTH,
    parameter int BUFFER_DEPTH  = 8,
    parameter int USEDW_WIDTH   = 8,
    parameter int MAX_PKT_FLITS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS-1:0]            in_last,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]           buf_in,
    output logic                            buf_produce,
    input  logic                            buf_full,
    input  logic [USEDW_WIDTH-1:0]          buf_usedw,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy,
    output logic [15:0]                     pkt_count,
    output logic                            len_err
);

    import router_pkg::*;

    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW  = $clog2(MAX_PKT_FLITS) + 1;
    localparam int FW1 = USEDW_WIDTH + 1;

    arb_state_t           state;
    logic [PW-1:0]        rr_ptr;
    logic [CW-1:0]        flit_cnt;
    logic [FW1-1:0]       free;
    logic [NUM_PORTS-1:0] win_gnt;
    logic                 win_valid;
    logic [PW-1:0]        g_idx;
    logic                 admit;
    logic                 at_max;
    logic                 pkt_end;
    logic                 over_len;

    rr_arbiter #(
        .N  (NUM_PORTS),
        .PW (PW)
    ) u_rr (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .gnt   (win_gnt),
        .valid (win_valid)
    );

    // Free space; a full FIFO counts as zero even if usedw has wrapped to 0.
    always_comb begin
        free = '0;
        if (!buf_full)
            free = FW1'(BUFFER_DEPTH) - {1'b0, buf_usedw};
    end

    assign admit = win_valid && (free >= FW1'(MAX_PKT_FLITS));

    // Index of the granted port; 0 when idle so buf_in then shows port 0.
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (grant[i])
                g_idx = PW'(i);
    end

    // Zero-latency write path from valid/full to ready/produce.
    always_comb begin
        in_ready    = busy ? (grant & {NUM_PORTS{~buf_full}}) : '0;
        buf_produce = busy & in_valid[g_idx] & ~buf_full;
        buf_in      = in_flit[int'(g_idx)*FLIT_WIDTH +: FLIT_WIDTH];
    end

    assign at_max   = (flit_cnt == CW'(MAX_PKT_FLITS-1));
    assign pkt_end  = buf_produce && (in_last[g_idx] || at_max);
    assign over_len = buf_produce && !in_last[g_idx] && at_max;

    // Arbitration FSM: grant on admission, release on tail or length cap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            pkt_count <= '0;
            len_err   <= 1'b0;
            rr_ptr    <= '0;
            flit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (admit) begin
                        grant    <= win_gnt;
                        busy     <= 1'b1;
                        flit_cnt <= '0;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (pkt_end) begin
                        state     <= IDLE;
                        grant     <= '0;
                        busy      <= 1'b0;
                        pkt_count <= pkt_count + 16'd1;
                        rr_ptr    <= (g_idx == PW'(NUM_PORTS-1)) ? '0 : g_idx + PW'(1);
                        if (over_len)
                            len_err <= 1'b1;
                    end else if (buf_produce) begin
                        flit_cnt <= flit_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Bench for buffer_write_arbiter: directed scenarios plus random traffic,
// all checked against a packet-level reference model of the arbiter.
module tb_buffer_write_arbiter;

    localparam int NP    = 4;
    localparam int FW    = 64;
    localparam int DEPTH = 8;
    localparam int UW    = 8;
    localparam int MAXF  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*FW-1:0]  in_flit;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_last;
    logic [NP-1:0]     in_ready;
    logic [FW-1:0]     buf_in;
    logic              buf_produce;
    logic              buf_full;
    logic [UW-1:0]     buf_usedw;
    logic [NP-1:0]     grant;
    logic              busy;
    logic [15:0]       pkt_count;
    logic              len_err;

    always #5 clk = ~clk;

    buffer_write_arbiter #(
        .NUM_PORTS     (NP),
        .FLIT_WIDTH    (FW),
        .BUFFER_DEPTH  (DEPTH),
        .USEDW_WIDTH   (UW),
        .MAX_PKT_FLITS (MAXF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_flit     (in_flit),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .buf_in      (buf_in),
        .buf_produce (buf_produce),
        .buf_full    (buf_full),
        .buf_usedw   (buf_usedw),
        .grant       (grant),
        .busy        (busy),
        .pkt_count   (pkt_count),
        .len_err     (len_err)
    );

    typedef struct packed {
        logic [FW-1:0] data;
        logic          last;
    } flit_t;

    flit_t       src_q [NP][$];
    logic [NP-1:0] hold;
    int          total = 0;
    int          bad   = 0;

    // reference model: owner port (-1 = none), flits taken, next start port
    int          m_owner;
    int          m_cnt;
    int          m_ptr;
    int          m_pkts;
    logic        m_len_err;

    int          cyc;
    int          wlog_port[$];
    int          wlog_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_cnt     = 0;
        m_ptr     = 0;
        m_pkts    = 0;
        m_len_err = 1'b0;
    endtask

    task automatic push_pkt(input int p, input int len, input logic [FW-1:0] base);
        for (int i = 0; i < len; i++)
            src_q[p].push_back('{data: base + FW'(i), last: (i == len-1)});
    endtask

    function automatic bit pending();
        bit r;
        r = (m_owner >= 0);
        for (int p = 0; p < NP; p++)
            if (src_q[p].size() > 0) r = 1'b1;
        return r;
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0 && !hold[p]) begin
                in_valid[p]          = 1'b1;
                in_flit[p*FW +: FW]  = src_q[p][0].data;
                in_last[p]           = src_q[p][0].last;
            end else begin
                in_valid[p]          = 1'b0;
                in_flit[p*FW +: FW]  = {$urandom, $urandom};
                in_last[p]           = 1'($urandom);
            end
        end
    endtask

    // one clock: compare at negedge, advance the model, return at posedge+1
    task automatic step();
        logic [NP-1:0] e_grant;
        logic [NP-1:0] e_ready;
        logic          e_prod;
        logic          was_last;
        int            e_free;
        bit            found;
        int            p;
        @(negedge clk);
        e_grant = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        e_free  = buf_full ? 0 : DEPTH - int'(buf_usedw);
        e_prod  = (m_owner >= 0) && in_valid[m_owner] && !buf_full;
        e_ready = ((m_owner >= 0) && !buf_full) ? e_grant : '0;
        chk("grant", grant, e_grant);
        chk("busy", busy, (m_owner >= 0));
        chk("in_ready", in_ready, e_ready);
        chk("buf_produce", buf_produce, e_prod);
        chk("pkt_count", pkt_count, 64'(m_pkts % 65536));
        chk("len_err", len_err, m_len_err);
        if (e_prod)
            chk("buf_in", buf_in, src_q[m_owner][0].data);

        if (m_owner < 0) begin
            if (in_valid != '0 && e_free >= MAXF) begin
                found = 1'b0;
                for (int k = 0; k < NP; k++) begin
                    p = (m_ptr + k) % NP;
                    if (!found && in_valid[p]) begin
                        found   = 1'b1;
                        m_owner = p;
                        m_cnt   = 0;
                    end
                end
            end
        end else if (e_prod) begin
            wlog_port.push_back(m_owner);
            wlog_cyc.push_back(cyc);
            was_last = src_q[m_owner][0].last;
            void'(src_q[m_owner].pop_front());
            m_cnt++;
            if (was_last || m_cnt == MAXF) begin
                if (!was_last) m_len_err = 1'b1;
                m_pkts++;
                m_ptr   = (m_owner + 1) % NP;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            step();
        end
    endtask

    task automatic run_until_idle(input int budget);
        int c;
        c = 0;
        while (pending() && c < budget) begin
            drive();
            step();
            c++;
        end
        chk("drain_timeout", pending(), 0);
    endtask

    task automatic clear_log();
        wlog_port.delete();
        wlog_cyc.delete();
        cyc = 0;
    endtask

    int exp_order [6] = '{0, 0, 2, 2, 3, 3};
    int pk_before;
    int start_n;
    int guard;

    initial begin
        hold      = '0;
        rst       = 1'b0;
        in_valid  = NP'($urandom);
        in_last   = NP'($urandom);
        buf_full  = 1'($urandom);
        buf_usedw = UW'($urandom);
        for (int p = 0; p < NP; p++) in_flit[p*FW +: FW] = {$urandom, $urandom};
        model_reset();
        clear_log();

        // reset with random inputs: everything quiet
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_produce", buf_produce, 0);

        @(negedge clk);
        rst       = 1'b1;
        buf_full  = 1'b0;
        buf_usedw = '0;
        run(2);

        // contention: ports 0,2,3 with 2-flit packets from pointer 0
        push_pkt(0, 2, 64'h100);
        push_pkt(2, 2, 64'h200);
        push_pkt(3, 2, 64'h300);
        clear_log();
        run_until_idle(40);
        chk("order_len", wlog_port.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < wlog_port.size())
                chk($sformatf("order%0d", i), wlog_port[i], exp_order[i]);
        if (wlog_cyc.size() > 0)
            chk("contention_cycles", wlog_cyc[wlog_cyc.size()-1], 8);

        // single 3-flit packet on port 1
        push_pkt(1, 3, 64'hA0);
        clear_log();
        run_until_idle(20);
        chk("single_writes", wlog_port.size(), 3);
        if (wlog_cyc.size() > 0)
            chk("single_first_write_cycle", wlog_cyc[0], 1);
        chk("single_pkt_count", pkt_count, 4);

        // admission: usedw=5 blocks, usedw=4 admits
        buf_usedw = 8'd5;
        push_pkt(2, 2, 64'h500);
        run(3);
        chk("adm_blocked", busy, 0);
        buf_usedw = 8'd4;
        run(1);
        chk("adm_grant", grant, 4'b0100);
        buf_usedw = '0;
        run_until_idle(20);

        // full with usedw wrapped to 0 blocks admission
        buf_full  = 1'b1;
        buf_usedw = '0;
        push_pkt(3, 1, 64'h600);
        run(3);
        chk("adm_full_blocked", busy, 0);
        buf_full = 1'b0;
        run_until_idle(20);

        // over-length: 6 flits, tail only on the sixth
        chk("len_err_pre", len_err, 0);
        pk_before = m_pkts;
        for (int i = 0; i < 6; i++)
            src_q[0].push_back('{data: 64'h700 + FW'(i), last: (i == 5)});
        run_until_idle(30);
        chk("overlen_len_err", len_err, 1);
        chk("overlen_pkts", pkt_count, 64'(pk_before + 2));

        // reset after 2 of 4 flits
        push_pkt(3, 4, 64'hD00);
        start_n = wlog_port.size();
        guard   = 0;
        while (wlog_port.size() < start_n + 2 && guard < 20) begin
            drive();
            step();
            guard++;
        end
        chk("mid_reset_reached", (wlog_port.size() >= start_n + 2), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pkt_count", pkt_count, 0);
        chk("mid_rst_produce", buf_produce, 0);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_pkt(1, 2, 64'hE00);
        clear_log();
        run_until_idle(20);
        if (wlog_cyc.size() > 0)
            chk("post_reset_first_write", wlog_cyc[0], 1);
        chk("post_reset_pkts", pkt_count, 1);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < NP; p++)
                if (src_q[p].size() == 0 && ($urandom % 4) == 0)
                    push_pkt(p, 1 + int'($urandom % 6), {$urandom, $urandom});
            for (int p = 0; p < NP; p++) hold[p] = (($urandom % 4) == 0);
            buf_full  = (($urandom % 10) == 0);
            buf_usedw = UW'($urandom % 9);
            drive();
            step();
        end
        hold      = '0;
        buf_full  = 1'b0;
        buf_usedw = '0;
        run_until_idle(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
